// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: ALU function opcodes plus the command, response and ALU
// bus between the control unit, the sequencer and the shared ALU.
package opcodes;
    typedef enum logic [3:0] {FnMem, FnADD, FnSUB, FnAND, FnOR, FnXOR, FnLSL, FnLSR} alu_functions_t;
endpackage

interface alu_sequencer_if #(parameter int WIDTH = 16);
    import opcodes::*;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    alu_functions_t   cmd_fn;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic             busy;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    alu_functions_t   alu_function;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zflag;
    // master is the surrounding system: control unit plus the ALU instance
    modport master (
        output cmd_valid, cmd_kind, cmd_fn, cmd_a, cmd_b, resp_ready, alu_result, alu_zflag,
        input  cmd_ready, resp_valid, resp_data, resp_zero, busy, alu_op1, alu_op2, alu_function
    );
    modport slave (
        input  cmd_valid, cmd_kind, cmd_fn, cmd_a, cmd_b, resp_ready, alu_result, alu_zflag,
        output cmd_ready, resp_valid, resp_data, resp_zero, busy, alu_op1, alu_op2, alu_function
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command sequencer driving the shared ALU for single
// ops, shift-by-N and shift-add 16x16 multiply (low half).
module alu_sequencer
    import opcodes::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SINGLE, SHIFT, MUL_ADD, MUL_SHA, MUL_SHB, MUL_FIN, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] a, b, acc, resp_data, op1, op2;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       kind;
    logic             resp_zero;
    alu_functions_t   fn, afn;
    assign bus.cmd_ready    = state == IDLE;
    assign bus.busy         = state != IDLE;
    assign bus.resp_valid   = state == DONE;
    assign bus.resp_data    = resp_data;
    assign bus.resp_zero    = resp_zero;
    assign bus.alu_op1      = op1;
    assign bus.alu_op2      = op2;
    assign bus.alu_function = afn;
    always_comb begin
        nxt = state;
        op1 = '0;
        op2 = '0;
        afn = FnMem;
        case (state)
            IDLE: nxt = !bus.cmd_valid ? IDLE : bus.cmd_kind == 2'b00 ? SINGLE :
                        bus.cmd_kind == 2'b11 ? MUL_ADD : SHIFT;
            SINGLE: begin
                op1 = a;
                op2 = b;
                afn = fn;
                nxt = DONE;
            end
            SHIFT: begin
                op1 = a;
                afn = cnt == '0 ? FnMem : kind == 2'b01 ? FnLSL : FnLSR;
                nxt = cnt == '0 ? DONE : SHIFT;
            end
            MUL_ADD: begin
                op1 = acc;
                op2 = b[0] ? a : '0;
                afn = b[0] ? FnADD : FnMem;
                nxt = MUL_SHA;
            end
            MUL_SHA: begin
                op1 = a;
                afn = FnLSL;
                nxt = MUL_SHB;
            end
            // the ALU zero flag on the shifted multiplier ends the loop
            MUL_SHB: begin
                op1 = b;
                afn = FnLSR;
                nxt = bus.alu_zflag ? MUL_FIN : MUL_ADD;
            end
            MUL_FIN: begin
                op1 = acc;
                nxt = DONE;
            end
            DONE: nxt = bus.resp_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            cnt       <= '0;
            kind      <= '0;
            fn        <= FnMem;
            resp_data <= '0;
            resp_zero <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    a    <= bus.cmd_a;
                    b    <= bus.cmd_b;
                    cnt  <= bus.cmd_b[CNT_W-1:0];
                    acc  <= '0;
                    fn   <= bus.cmd_fn;
                    kind <= bus.cmd_kind;
                end
                SINGLE, MUL_FIN: begin
                    resp_data <= bus.alu_result;
                    resp_zero <= bus.alu_zflag;
                end
                SHIFT: if (cnt == '0) begin
                    resp_data <= bus.alu_result;
                    resp_zero <= bus.alu_zflag;
                end else begin
                    a   <= bus.alu_result;
                    cnt <= cnt - 1'b1;
                end
                MUL_ADD: if (b[0]) acc <= bus.alu_result;
                MUL_SHA: a <= bus.alu_result;
                MUL_SHB: b <= bus.alu_result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a behavioural ALU
// attached to the ALU side of the bus.
module tb_alu_sequencer;
    import opcodes::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_sequencer_if bus();
    alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_rsp = 0;
    bit rec = 1'b0;
    alu_functions_t trace[$];
    alu_functions_t exp_tr[14] = '{FnXOR, FnLSR, FnLSR, FnMem,
                                   FnADD, FnLSL, FnLSR, FnMem, FnLSL, FnLSR, FnADD, FnLSL, FnLSR, FnMem};
    logic [15:0] r;
    always_comb begin
        case (bus.alu_function)
            FnADD:   r = bus.alu_op1 + bus.alu_op2;
            FnSUB:   r = bus.alu_op1 - bus.alu_op2;
            FnAND:   r = bus.alu_op1 & bus.alu_op2;
            FnOR:    r = bus.alu_op1 | bus.alu_op2;
            FnXOR:   r = bus.alu_op1 ^ bus.alu_op2;
            FnLSL:   r = bus.alu_op1 << 1;
            FnLSR:   r = bus.alu_op1 >> 1;
            default: r = bus.alu_op1;
        endcase
        bus.alu_result = r;
        bus.alu_zflag  = r == 16'h0;
    end
    always @(posedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) n_acc <= n_acc + 1;
        if (bus.resp_valid && bus.resp_ready) n_rsp <= n_rsp + 1;
        if (rec && bus.busy && !bus.resp_valid) trace.push_back(bus.alu_function);
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    // n counts clock edges from the accept edge up to the edge entering DONE
    task automatic run(input logic [1:0] k, input alu_functions_t f, input logic [15:0] a,
                       input logic [15:0] b, output int n);
        int w = 0;
        bus.cmd_kind  = k;
        bus.cmd_fn    = f;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic op(input string tag, input logic [1:0] k, input alu_functions_t f,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ed, input logic ez, input int en);
        int n;
        run(k, f, a, b, n);
        chk({tag, "_valid"}, bus.resp_valid, 1);
        chk({tag, "_data"}, bus.resp_data, ed);
        chk({tag, "_zero"}, bus.resp_zero, ez);
        chk({tag, "_lat"}, n, en);
    endtask
    initial begin
        int n, s0, r0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_kind   = 2'b00;
        bus.cmd_fn     = FnMem;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.resp_ready = 1'b1;
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_zero", bus.resp_zero, 0);
        chk("rst_op1", bus.alu_op1, 0);
        chk("rst_op2", bus.alu_op2, 0);
        chk("rst_fn", bus.alu_function, FnMem);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op("add", 2'b00, FnADD, 16'h1234, 16'h0011, 16'h1245, 1'b0, 2);
        op("sub", 2'b00, FnSUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 2);
        op("shl4", 2'b01, FnMem, 16'h0001, 16'h0004, 16'h0010, 1'b0, 6);
        op("shr15", 2'b10, FnMem, 16'h8000, 16'h000F, 16'h0001, 1'b0, 17);
        op("shl0", 2'b01, FnMem, 16'h0001, 16'h0030, 16'h0001, 1'b0, 2);
        op("mul3x5", 2'b11, FnMem, 16'h0003, 16'h0005, 16'h000F, 1'b0, 11);
        op("mul100", 2'b11, FnMem, 16'h0100, 16'h0100, 16'h0000, 1'b1, 29);
        op("mulx0", 2'b11, FnMem, 16'h1234, 16'h0000, 16'h0000, 1'b1, 5);
        op("mulffff", 2'b11, FnMem, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 50);
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        run(2'b00, FnAND, 16'hFF00, 16'h0FF0, n);
        chk("bp_data0", bus.resp_data, 16'h0F00);
        s0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = (i == 2);
            @(posedge clk); #1;
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_data", bus.resp_data, 16'h0F00);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0;
        chk("bp_no_accept", n_acc - s0, 0);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_busy", bus.busy, 0);
        chk("bp_idle_ready", bus.cmd_ready, 1);
        chk("bp_idle_valid", bus.resp_valid, 0);
        chk("bp_idle_data", bus.resp_data, 16'h0F00);
        bus.cmd_kind  = 2'b11;
        bus.cmd_a     = 16'h0003;
        bus.cmd_b     = 16'h0005;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rm_in_sha", bus.alu_function, FnLSL);
        chk("rm_sha_op1", bus.alu_op1, 16'h0003);
        rst_n = 1'b0;
        #1;
        chk("rm_cmd_ready", bus.cmd_ready, 1);
        chk("rm_busy", bus.busy, 0);
        chk("rm_resp_valid", bus.resp_valid, 0);
        chk("rm_resp_data", bus.resp_data, 0);
        chk("rm_fn", bus.alu_function, FnMem);
        chk("rm_op1", bus.alu_op1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rm_after_valid", bus.resp_valid, 0);
            chk("rm_after_busy", bus.busy, 0);
        end
        op("or", 2'b00, FnOR, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 2);
        @(posedge clk); #1;
        s0 = n_acc;
        r0 = n_rsp;
        trace.delete();
        rec = 1'b1;
        op("b2b_xor", 2'b00, FnXOR, 16'hAAAA, 16'h0F0F, 16'hA5A5, 1'b0, 2);
        op("b2b_shr", 2'b10, FnMem, 16'h00F0, 16'h0002, 16'h003C, 1'b0, 4);
        op("b2b_mul", 2'b11, FnMem, 16'h0003, 16'h0005, 16'h000F, 1'b0, 11);
        @(posedge clk); #1;
        rec = 1'b0;
        chk("b2b_accepts", n_acc - s0, 3);
        chk("b2b_responses", n_rsp - r0, 3);
        chk("b2b_trace_len", trace.size(), 14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("b2b_trace_%0d", i), (i < trace.size()) ? trace[i] : 4'hF, exp_tr[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle command sequencer in front of the shared 16-bit ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU's Op1/Op2/Function inputs cycle by cycle, capturing Result/Zflag back into internal registers. Alongside single ALU operations it provides shift-by-N and 16x16 multiply (low 16 bits, shift-add) built from repeated FnLSL/FnLSR/FnADD/FnMem steps. It sits between the control unit and the ALU instance.

Parameters:
WIDTH, 16, datapath width; must match the ALU (only 16 is supported).
CNT_W, 4, shift-count width; the count is taken from CmdB[CNT_W-1:0].

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
CmdValid  input  1  command present
CmdReady  output  1  sequencer can accept a command
CmdKind  input  2  00 SINGLE, 01 SHLN, 10 SHRN, 11 MUL
CmdFn  input  opcodes::alu_functions_t  ALU function for SINGLE; ignored otherwise
CmdA  input  16  operand A
CmdB  input  16  operand B, shift count or multiplier
RespValid  output  1  result available
RespReady  input  1  consumer takes the result
RespData  output  16  result
RespZero  output  1  result == 0
Busy  output  1  state != IDLE
AluOp1  output  16  to ALU Op1
AluOp2  output  16  to ALU Op2
AluFunction  output  opcodes::alu_functions_t  to ALU Function
AluResult  input  16  from ALU Result
AluZflag  input  1  from ALU Zflag

Behaviour:
- Reset state: IDLE, registers A/B/Acc/Cnt/RespData = 0, RespZero = 0, RespValid = 0, Busy = 0, CmdReady = 1. ALU outputs idle at Op1 = Op2 = 0, FnMem.
- CmdReady = 1 only in IDLE. Accept happens when CmdValid & CmdReady on a rising edge. On accept, latch A = CmdA, B = CmdB, Cnt = CmdB[3:0], Acc = 0, Fn and Kind. CmdValid outside IDLE is ignored, and the requester holds it.
- States: IDLE, SINGLE, SHIFT, MUL_ADD, MUL_SHA, MUL_SHB, MUL_FIN, DONE.
- In any non-DONE state, ALU outputs not listed below are Op2 = 0 and Function = FnMem.
- SINGLE: drive Op1 = A, Op2 = B, Function = Fn. Capture AluResult into RespData and AluZflag into RespZero, then go to DONE. RespValid rises 2 cycles after the accept edge.
- SHIFT with Cnt == 0: drive FnMem with Op1 = A, capture the result and go to DONE.
- SHIFT with Cnt != 0: drive Op1 = A and Function = FnLSL (SHLN) or FnLSR (SHRN). Update A <= AluResult and Cnt <= Cnt - 1, staying in SHIFT. This takes N+1 ALU cycles; CmdB[15:4] is ignored. Shifts fill with zeros.
- MUL_ADD: if B[0] = 1, drive Op1 = Acc, Op2 = A, FnADD and load Acc <= AluResult. Otherwise drive FnMem with Op1 = Acc and leave Acc unchanged. Next state is MUL_SHA.
- MUL_SHA: drive Op1 = A, FnLSL; A <= AluResult; next state is MUL_SHB.
- MUL_SHB: drive Op1 = B, FnLSR; B <= AluResult. If AluZflag, go to MUL_FIN; otherwise go to MUL_ADD.
- MUL_FIN: drive FnMem with Op1 = Acc, capture RespData/RespZero, go to DONE.
- MUL result = (CmdA*CmdB) mod 2^16. Number of iterations k = max(1, index of the highest set bit of CmdB + 1), so k ≤ 16. ALU cycles = 3k + 1.
- DONE: RespValid = 1; RespData and RespZero are held stable. On RespReady, go to IDLE. A new accept is therefore possible at the earliest 1 cycle after the response handshake. RespValid is never dropped without RespReady.
- RespData and RespZero keep their last values in IDLE.
- Reset asserted mid-operation: immediate return to reset values, no response is produced, and the partial state is discarded.
- No combinational path from CmdValid to CmdReady or from RespReady to RespValid. ALU outputs are combinational from state and registers only.

Test Plan:
1. SINGLE FnADD, A = 0x1234, B = 0x0011 → RespData 0x1245, RespZero 0, RespValid 2 cycles after accept. SINGLE FnSUB 0x0005 - 0x0005 → 0x0000, RespZero 1.
2. SHLN A = 0x0001, B = 0x0004 → 0x0010 after 5 ALU cycles. SHRN A = 0x8000, B = 0x000F → 0x0001. SHLN B = 0x0030 (count 0) → 0x0001 unchanged after 1 ALU cycle.
3. MUL 0x0003 × 0x0005 → 0x000F, 10 ALU cycles. MUL 0x0100 × 0x0100 → 0x0000, RespZero 1. MUL 0x1234 × 0x0000 → 0x0000, RespZero 1, 4 ALU cycles. MUL 0xFFFF × 0xFFFF → 0x0001.
4. Backpressure: hold RespReady low for 5 cycles in DONE → RespValid and RespData stay constant, CmdReady stays 0, a pulsed CmdValid is not accepted. Release RespReady → IDLE next cycle.
5. Reset mid-MUL (nReset low during MUL_SHA) → all outputs at reset values asynchronously, no RespValid. After release, SINGLE FnOR 0x00F0 | 0x0F00 → 0x0FF0.
6. Back-to-back SINGLE, SHRN and MUL commands with RespReady tied high → results returned in order, exactly one accept per response, ALU Function sequence matches the state trace.
